cache2vias_ctrl: RTL and testbench



---
 rtl/cache2vias_pkg.sv | 26 ++
 rtl/cache2vias_meta.sv | 108 ++++++++++
 rtl/cache2vias_ctrl.sv | 259 +++++++++++++++++++++++++
 tb/tb_cache2vias_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/cache2vias_pkg.sv
// cache2vias_pkg: shared types and constants for the 2-way cache controller.
//   state_e       - controller state encoding (IDLE, LOOKUP, WB, FILL, ACK)
//   ARR_SRC_*     - data-array write source select values
//   *_DEF         - default address/index widths
//   sat_inc8      - saturating 8-bit increment for the optional statistics
package cache2vias_pkg;

  localparam int ADDR_W_DEF  = 5;
  localparam int INDEX_W_DEF = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    WB     = 3'd2,
    FILL   = 3'd3,
    ACK    = 3'd4
  } state_e;

  localparam logic ARR_SRC_CPU = 1'b0;
  localparam logic ARR_SRC_MEM = 1'b1;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/cache2vias_meta.sv
// cache2vias_meta: tag/valid/dirty/LRU metadata for a 2-way set-associative cache.
// Ports:
//   clock, resetn      - clock, async active-low reset (clears everything)
//   index, tag         - set and tag being looked up / updated
//   hit, hit_way       - combinational lookup result (way0 wins on double hit)
//   victim             - first invalid way (way0 first), else LRU way of the set
//   victim_dirty       - victim is valid and dirty
//   rd_way, rd_tag     - tag readback of one way of the set (writeback address)
//   upd_way            - way targeted by the update strobes below
//   touch_en           - mark upd_way most recently used
//   dirty_set_en/_clr  - set/clear dirty of upd_way
//   fill_en            - install tag into upd_way: valid=1, dirty=0
module cache2vias_meta
  import cache2vias_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INDEX_W = INDEX_W_DEF
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic [INDEX_W-1:0]        index,
  input  logic [ADDR_W-INDEX_W-1:0] tag,
  output logic                      hit,
  output logic                      hit_way,
  output logic                      victim,
  output logic                      victim_dirty,
  input  logic                      rd_way,
  output logic [ADDR_W-INDEX_W-1:0] rd_tag,
  input  logic                      upd_way,
  input  logic                      touch_en,
  input  logic                      dirty_set_en,
  input  logic                      dirty_clr_en,
  input  logic                      fill_en
);

  localparam int SETS  = 1 << INDEX_W;
  localparam int TAG_W = ADDR_W - INDEX_W;

  logic [1:0][SETS-1:0]            valid_q, valid_d;
  logic [1:0][SETS-1:0]            dirty_q, dirty_d;
  logic [SETS-1:0]                 lru_q, lru_d;   // per set: way to evict next
  logic [1:0][SETS-1:0][TAG_W-1:0] tag_q, tag_d;
  logic                            hit0_s, hit1_s;

  // Lookup, victim choice and tag readback for the selected set
  always_comb begin
    hit0_s = valid_q[0][index] && (tag_q[0][index] == tag);
    hit1_s = valid_q[1][index] && (tag_q[1][index] == tag);
    hit    = hit0_s || hit1_s;
    if (hit0_s) begin
      hit_way = 1'b0;
    end else begin
      hit_way = 1'b1;
    end
    if (!valid_q[0][index]) begin
      victim = 1'b0;
    end else if (!valid_q[1][index]) begin
      victim = 1'b1;
    end else begin
      victim = lru_q[index];
    end
    victim_dirty = valid_q[victim][index] && dirty_q[victim][index];
    rd_tag       = tag_q[rd_way][index];
  end

  // Next-state of the metadata from the one-cycle update strobes
  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    lru_d   = lru_q;
    tag_d   = tag_q;
    if (touch_en) begin
      lru_d[index] = ~upd_way;
    end else begin
      lru_d[index] = lru_q[index];
    end
    if (dirty_set_en) begin
      dirty_d[upd_way][index] = 1'b1;
    end else if (dirty_clr_en) begin
      dirty_d[upd_way][index] = 1'b0;
    end else begin
      dirty_d[upd_way][index] = dirty_q[upd_way][index];
    end
    if (fill_en) begin
      valid_d[upd_way][index] = 1'b1;
      dirty_d[upd_way][index] = 1'b0;
      tag_d[upd_way][index]   = tag;
    end else begin
      valid_d[upd_way][index] = valid_q[upd_way][index];
    end
  end

  // Metadata flop array
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      valid_q <= '0;
      dirty_q <= '0;
      lru_q   <= '0;
      tag_q   <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
      lru_q   <= lru_d;
      tag_q   <= tag_d;
    end
  end

endmodule

// File: rtl/cache2vias_ctrl.sv
// cache2vias_ctrl: sequencing controller for a 2-way set-associative cache.
// Runs the CPU handshake, owns the metadata (via cache2vias_meta) and drives
// the data-array strobes and main-memory writeback/refill requests.
// Ports:
//   clock, resetn                 - clock, async active-low reset
//   cpu_req/cpu_we/cpu_addr       - CPU access, latched on acceptance
//   cpu_ack/cpu_hit               - one-cycle completion, original-lookup hit
//   busy                          - controller not in IDLE
//   arr_we/arr_way/arr_index/arr_src - data-array control
//   mem_req/mem_we/mem_addr/mem_ready - main-memory handshake
//   hit_count/miss_count          - saturating statistics, only when the
//                                   CACHE_STATS_EN macro is defined
// All outputs are registered. Memory-side outputs and busy are registered from
// the next state so they line up with WB/FILL; cpu_ack and array strobes are
// registered from the decision made in the current state.
module cache2vias_ctrl
  import cache2vias_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INDEX_W = INDEX_W_DEF
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [ADDR_W-1:0]  cpu_addr,
  output logic               cpu_ack,
  output logic               cpu_hit,
  output logic               busy,
  output logic               arr_we,
  output logic               arr_way,
  output logic [INDEX_W-1:0] arr_index,
  output logic               arr_src,
  output logic               mem_req,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
`ifdef CACHE_STATS_EN
  output logic [7:0]         hit_count,
  output logic [7:0]         miss_count,
`endif
  input  logic               mem_ready
);

  localparam int TAG_W = ADDR_W - INDEX_W;

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                miss_q, miss_d;
  logic                victim_q, victim_d;
  logic                cpu_ack_q, cpu_ack_d, cpu_hit_q, cpu_hit_d, busy_q, busy_d;
  logic                arr_we_q, arr_we_d, arr_way_q, arr_way_d, arr_src_q, arr_src_d;
  logic [INDEX_W-1:0]  arr_index_q, arr_index_d;
  logic                mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
`ifdef CACHE_STATS_EN
  logic [7:0]          hit_count_q, hit_count_d, miss_count_q, miss_count_d;
`endif

  logic                hit_s, hit_way_s, victim_s, victim_dirty_s;
  logic [TAG_W-1:0]    rd_tag_s;
  logic                upd_way_s, touch_en_s, dirty_set_s, dirty_clr_s, fill_en_s;

  cache2vias_meta #(.ADDR_W(ADDR_W), .INDEX_W(INDEX_W)) u_meta (
    .clock        (clock),
    .resetn       (resetn),
    .index        (addr_q[INDEX_W-1:0]),
    .tag          (addr_q[ADDR_W-1:INDEX_W]),
    .hit          (hit_s),
    .hit_way      (hit_way_s),
    .victim       (victim_s),
    .victim_dirty (victim_dirty_s),
    .rd_way       (victim_d),
    .rd_tag       (rd_tag_s),
    .upd_way      (upd_way_s),
    .touch_en     (touch_en_s),
    .dirty_set_en (dirty_set_s),
    .dirty_clr_en (dirty_clr_s),
    .fill_en      (fill_en_s)
  );

  // FSM next state, metadata updates and next values of the registered outputs
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    miss_d      = miss_q;
    victim_d    = victim_q;
    cpu_ack_d   = 1'b0;
    cpu_hit_d   = 1'b0;
    arr_we_d    = 1'b0;
    arr_src_d   = ARR_SRC_CPU;
    arr_way_d   = 1'b0;
    upd_way_s   = 1'b0;
    touch_en_s  = 1'b0;
    dirty_set_s = 1'b0;
    dirty_clr_s = 1'b0;
    fill_en_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          we_d    = cpu_we;
          addr_d  = cpu_addr;
          state_d = LOOKUP;
        end else begin
          state_d = IDLE;
        end
      end
      LOOKUP: begin
        if (hit_s) begin
          touch_en_s = 1'b1;
          upd_way_s  = hit_way_s;
          state_d    = ACK;
          if (we_q) begin
            arr_we_d    = 1'b1;
            arr_src_d   = ARR_SRC_CPU;
            arr_way_d   = hit_way_s;
            dirty_set_s = 1'b1;
          end else begin
            arr_we_d = 1'b0;
          end
        end else begin
          miss_d   = 1'b1;
          victim_d = victim_s;
          state_d  = victim_dirty_s ? WB : FILL;
        end
      end
      WB: begin
        if (mem_req_q && mem_ready) begin
          dirty_clr_s = 1'b1;
          upd_way_s   = victim_q;
          state_d     = FILL;
        end else begin
          state_d = WB;
        end
      end
      FILL: begin
        // The refill is followed by a fresh lookup, which hits and replays
        // the write-hit path for write misses.
        if (mem_req_q && mem_ready) begin
          fill_en_s = 1'b1;
          upd_way_s = victim_q;
          arr_we_d  = 1'b1;
          arr_src_d = ARR_SRC_MEM;
          arr_way_d = victim_q;
          state_d   = LOOKUP;
        end else begin
          state_d = FILL;
        end
      end
      ACK: begin
        cpu_ack_d = 1'b1;
        cpu_hit_d = !miss_q;
        miss_d    = 1'b0;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Memory-side outputs follow the state being entered so that a zero-wait
    // memory completes WB/FILL in a single cycle.
    busy_d      = (state_d != IDLE);
    mem_req_d   = (state_d == WB) || (state_d == FILL);
    mem_we_d    = (state_d == WB);
    arr_index_d = addr_d[INDEX_W-1:0];
    case (state_d)
      WB: begin
        mem_addr_d = {rd_tag_s, addr_q[INDEX_W-1:0]};
        arr_way_d  = victim_d;
      end
      FILL: begin
        mem_addr_d = addr_q;
      end
      default: begin
        mem_addr_d = '0;
      end
    endcase
  end

`ifdef CACHE_STATS_EN
  // Saturating hit/miss counters, advanced together with cpu_ack
  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (cpu_ack_d) begin
      if (cpu_hit_d) begin
        hit_count_d = sat_inc8(hit_count_q);
      end else begin
        miss_count_d = sat_inc8(miss_count_q);
      end
    end else begin
      hit_count_d = hit_count_q;
    end
  end
`endif

  // Controller state and registered outputs
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      miss_q      <= 1'b0;
      victim_q    <= 1'b0;
      cpu_ack_q   <= 1'b0;
      cpu_hit_q   <= 1'b0;
      busy_q      <= 1'b0;
      arr_we_q    <= 1'b0;
      arr_way_q   <= 1'b0;
      arr_src_q   <= 1'b0;
      arr_index_q <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
`ifdef CACHE_STATS_EN
      hit_count_q  <= 8'd0;
      miss_count_q <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      miss_q      <= miss_d;
      victim_q    <= victim_d;
      cpu_ack_q   <= cpu_ack_d;
      cpu_hit_q   <= cpu_hit_d;
      busy_q      <= busy_d;
      arr_we_q    <= arr_we_d;
      arr_way_q   <= arr_way_d;
      arr_src_q   <= arr_src_d;
      arr_index_q <= arr_index_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
`ifdef CACHE_STATS_EN
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
`endif
    end
  end

  assign cpu_ack   = cpu_ack_q;
  assign cpu_hit   = cpu_hit_q;
  assign busy      = busy_q;
  assign arr_we    = arr_we_q;
  assign arr_way   = arr_way_q;
  assign arr_src   = arr_src_q;
  assign arr_index = arr_index_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
`ifdef CACHE_STATS_EN
  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_cache2vias_ctrl.sv
// tb_cache2vias_ctrl: directed scoreboard bench for cache2vias_ctrl.
// Expected array writes, memory transactions and hit flags are queued when an
// access is issued and consumed as the controller produces them.
module tb_cache2vias_ctrl;

  logic       clock = 1'b0;
  logic       resetn;
  logic       cpu_req, cpu_we, mem_ready;
  logic [4:0] cpu_addr;
  logic       cpu_ack, cpu_hit, busy, arr_we, arr_way, arr_src, mem_req, mem_we;
  logic [1:0] arr_index;
  logic [4:0] mem_addr;
`ifdef CACHE_STATS_EN
  logic [7:0] hit_count, miss_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [5:0] exp_mem_q[$];  // {mem_we, mem_addr} at completion
  logic [3:0] exp_arr_q[$];  // {arr_way, arr_src, arr_index} per strobe
  logic       exp_hit_q[$];

  cache2vias_ctrl dut (
    .clock     (clock),
    .resetn    (resetn),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_ack   (cpu_ack),
    .cpu_hit   (cpu_hit),
    .busy      (busy),
    .arr_we    (arr_we),
    .arr_way   (arr_way),
    .arr_index (arr_index),
    .arr_src   (arr_src),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
`ifdef CACHE_STATS_EN
    .hit_count (hit_count),
    .miss_count(miss_count),
`endif
    .mem_ready (mem_ready)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    resetn    = 1'b0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = 5'd0;
    mem_ready = 1'b1;
    repeat (2) @(negedge clock);
    chk("reset_outputs",
        32'({cpu_ack, cpu_hit, busy, arr_we, arr_way, arr_src, arr_index, mem_req, mem_we, mem_addr}),
        32'd0);
    resetn = 1'b1;
    @(negedge clock);
  endtask

  // One CPU access. Called at a negedge; memory answers immediately except for
  // wb_stall cycles of not-ready during writeback. Midway through, the CPU-side
  // inputs are disturbed to show that the latched request is used.
  task automatic access(input logic we, input logic [4:0] addr, input logic exp_hit,
                        input int exp_lat, input int wb_stall);
    int         cyc;
    int         stall;
    bit         done;
    bit         prev_wait;
    logic [5:0] prev_mem;
    exp_hit_q.push_back(exp_hit);
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_req   = 1'b1;
    cyc       = 0;
    stall     = 0;
    done      = 1'b0;
    prev_wait = 1'b0;
    prev_mem  = 6'd0;
    while (!done && cyc < 60) begin
      @(negedge clock);
      cyc++;
      if (cyc == 2) begin
        cpu_req  = 1'b0;
        cpu_we   = ~we;
        cpu_addr = ~addr;
      end
      if (arr_we) begin
        if (exp_arr_q.size() == 0) chk("arr_we_unexpected", 32'(arr_we), 32'd0);
        else chk("arr_write", 32'({arr_way, arr_src, arr_index}), 32'(exp_arr_q.pop_front()));
      end
      if (prev_wait) chk("mem_hold", 32'({mem_req, mem_we, mem_addr}), 32'({1'b1, prev_mem}));
      mem_ready = !(mem_req && mem_we && stall < wb_stall);
      if (!mem_ready) stall++;
      prev_wait = mem_req && !mem_ready;
      prev_mem  = {mem_we, mem_addr};
      if (mem_req && mem_ready) begin
        if (exp_mem_q.size() == 0) chk("mem_unexpected", 32'(mem_req), 32'd0);
        else chk("mem_txn", 32'({mem_we, mem_addr}), 32'(exp_mem_q.pop_front()));
      end
      if (cpu_ack) begin
        done = 1'b1;
        chk("cpu_hit", 32'(cpu_hit), 32'(exp_hit_q.pop_front()));
        chk("ack_latency", 32'(cyc), 32'(exp_lat));
        chk("busy_at_ack", 32'(busy), 32'd0);
      end
    end
    if (!done) chk("ack_timeout", 32'(cpu_ack), 32'd1);
    cpu_req   = 1'b0;
    mem_ready = 1'b1;
    chk("arr_queue_drained", 32'(exp_arr_q.size()), 32'd0);
    chk("mem_queue_drained", 32'(exp_mem_q.size()), 32'd0);
    exp_arr_q.delete();
    exp_mem_q.delete();
    exp_hit_q.delete();
  endtask

  initial begin
    int c;
    do_reset();

    // Cold read miss fills way0 of set3, then hits
    exp_mem_q.push_back(6'h03); exp_arr_q.push_back(4'h7);
    access(1'b0, 5'h03, 1'b0, 5, 0);
    access(1'b0, 5'h03, 1'b1, 3, 0);
    // Write hit: CPU data into way0 set3, line becomes dirty
    exp_arr_q.push_back(4'h3);
    access(1'b1, 5'h03, 1'b1, 3, 0);
    // Same set, way1 empty: fills way1 without writeback
    exp_mem_q.push_back(6'h07); exp_arr_q.push_back(4'hF);
    access(1'b0, 5'h07, 1'b0, 5, 0);
    // LRU way0 is dirty: writeback 0x03 held 5 cycles, then refill 0x0B
    exp_mem_q.push_back(6'h23); exp_mem_q.push_back(6'h0B); exp_arr_q.push_back(4'h7);
    access(1'b0, 5'h0B, 1'b0, 11, 5);
    // Dirty 0x0B, touch way1, then zero-wait writeback of 0x0B for 0x0F
    exp_arr_q.push_back(4'h3);
    access(1'b1, 5'h0B, 1'b1, 3, 0);
    access(1'b0, 5'h07, 1'b1, 3, 0);
    exp_mem_q.push_back(6'h2B); exp_mem_q.push_back(6'h0F); exp_arr_q.push_back(4'h7);
    access(1'b0, 5'h0F, 1'b0, 6, 0);
    // Write miss in set0: refill, then CPU write on the re-lookup
    exp_mem_q.push_back(6'h10); exp_arr_q.push_back(4'h4); exp_arr_q.push_back(4'h0);
    access(1'b1, 5'h10, 1'b0, 5, 0);

    // Reset asserted while a refill is outstanding
    mem_ready = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = 5'h13;
    cpu_req   = 1'b1;
    c = 0;
    while (!(mem_req && !mem_we) && c < 10) begin
      @(negedge clock);
      c++;
    end
    chk("fill_reached", 32'({mem_req, mem_we, mem_addr}), 32'({2'b10, 5'h13}));
    #2 resetn = 1'b0;
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    cpu_req   = 1'b0;
    mem_ready = 1'b1;
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    // Metadata was cleared: 0x03 misses again
    exp_mem_q.push_back(6'h03); exp_arr_q.push_back(4'h7);
    access(1'b0, 5'h03, 1'b0, 5, 0);

`ifdef CACHE_STATS_EN
    do_reset();
    chk("stats_reset", 32'({hit_count, miss_count}), 32'd0);
    exp_mem_q.push_back(6'h03); exp_arr_q.push_back(4'h7);
    access(1'b0, 5'h03, 1'b0, 5, 0);
    for (int i = 0; i < 3; i++) access(1'b0, 5'h03, 1'b1, 3, 0);
    exp_mem_q.push_back(6'h07); exp_arr_q.push_back(4'hF);
    access(1'b0, 5'h07, 1'b0, 5, 0);
    chk("hit_count_3", 32'(hit_count), 32'd3);
    chk("miss_count_2", 32'(miss_count), 32'd2);
    for (int i = 0; i < 300; i++) access(1'b0, 5'h03, 1'b1, 3, 0);
    chk("hit_count_sat", 32'(hit_count), 32'd255);
    chk("miss_count_kept", 32'(miss_count), 32'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
